// File: rtl/testbench_refr_chk.sv
// Refresh-stream monitor: checks the M-in-N refresh rate over a sliding window,
// checks that refr trails refr_e by one cycle, and keeps running statistics.
module testbench_refr_chk #(
  parameter int unsigned REFRESH_M_IN_N_M = 0,
  parameter int unsigned REFRESH_M_IN_N_N = 0,
  parameter int unsigned MAX_N            = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        refr,
  input  logic        refr_e,
  output logic [15:0] win_cnt,
  output logic        win_full,
  output logic [31:0] refr_tot,
  output logic [15:0] max_run,
  output logic        err_rate,
  output logic        err_align
);

  localparam int unsigned M  = REFRESH_M_IN_N_M;
  localparam int unsigned N  = REFRESH_M_IN_N_N;
  // History is at least two bits wide so the pointer always has a real index bit.
  localparam int unsigned HW = (N < 2) ? 2 : N;
  localparam int unsigned PW = $clog2(HW);
  localparam int unsigned CW = 16;
  localparam int unsigned TW = 32;

  // Reject impossible window configurations at elaboration.
  generate
    if (N > MAX_N || M > N) begin : g_param_chk
      $fatal(1, "testbench_refr_chk: bad parameters M=%0d N=%0d MAX_N=%0d", M, N, MAX_N);
    end
  endgenerate

  logic [HW-1:0] hist_q,      hist_d;
  logic [PW-1:0] wp_q,        wp_d;
  logic [CW-1:0] fill_q,      fill_d;
  logic [CW-1:0] win_cnt_q,   win_cnt_d;
  logic          win_full_q,  win_full_d;
  logic [TW-1:0] tot_q,       tot_d;
  logic [CW-1:0] run_q,       run_d;
  logic [CW-1:0] max_run_q,   max_run_d;
  logic          err_rate_q,  err_rate_d;
  logic          err_align_q, err_align_d;
  logic          refr_e_dly_q, refr_e_dly_d;
  logic          v_q,         v_d;

  logic          leave;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] run_inc;

  // Next-state computation for one sample of refr / refr_e.
  always_comb begin
    hist_d       = hist_q;
    wp_d         = wp_q;
    fill_d       = fill_q;
    win_cnt_d    = win_cnt_q;
    win_full_d   = win_full_q;
    tot_d        = tot_q;
    run_d        = run_q;
    max_run_d    = max_run_q;
    err_rate_d   = err_rate_q;
    err_align_d  = err_align_q;
    refr_e_dly_d = refr_e;
    v_d          = 1'b1;

    // Leaving bit is read before the slot is overwritten.
    leave   = hist_q[wp_q];
    cnt_nxt = win_cnt_q + CW'(refr) - CW'(leave);
    run_inc = (run_q == '1) ? run_q : run_q + CW'(1);

    if (N != 0) begin
      win_cnt_d    = cnt_nxt;
      hist_d[wp_q] = refr;
      wp_d         = (wp_q == PW'(N - 1)) ? '0 : wp_q + PW'(1);
      if (fill_q != CW'(N)) begin
        fill_d = fill_q + CW'(1);
      end
      win_full_d = (fill_d == CW'(N));
      if (win_full_q && (cnt_nxt != CW'(M))) begin
        err_rate_d = 1'b1;
      end
    end else if (refr) begin
      err_rate_d = 1'b1;
    end

    if (refr && (tot_q != '1)) begin
      tot_d = tot_q + TW'(1);
    end

    run_d = refr ? run_inc : '0;
    if (refr && (run_inc > max_run_q)) begin
      max_run_d = run_inc;
    end

    if (v_q && (refr != refr_e_dly_q)) begin
      err_align_d = 1'b1;
    end
  end

  // State register with synchronous reset that also clears the history.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q       <= '0;
      wp_q         <= '0;
      fill_q       <= '0;
      win_cnt_q    <= '0;
      win_full_q   <= 1'b0;
      tot_q        <= '0;
      run_q        <= '0;
      max_run_q    <= '0;
      err_rate_q   <= 1'b0;
      err_align_q  <= 1'b0;
      refr_e_dly_q <= 1'b0;
      v_q          <= 1'b0;
    end else begin
      hist_q       <= hist_d;
      wp_q         <= wp_d;
      fill_q       <= fill_d;
      win_cnt_q    <= win_cnt_d;
      win_full_q   <= win_full_d;
      tot_q        <= tot_d;
      run_q        <= run_d;
      max_run_q    <= max_run_d;
      err_rate_q   <= err_rate_d;
      err_align_q  <= err_align_d;
      refr_e_dly_q <= refr_e_dly_d;
      v_q          <= v_d;
    end
  end

  assign win_cnt   = win_cnt_q;
  assign win_full  = win_full_q;
  assign refr_tot  = tot_q;
  assign max_run   = max_run_q;
  assign err_rate  = err_rate_q;
  assign err_align = err_align_q;

endmodule

// File: tb/tb_testbench_refr_chk.sv
// Bench for testbench_refr_chk: four instances with different M/N, driven by
// directed and random streams, compared each cycle against a sequence model.
module tb_testbench_refr_chk;

  localparam int NI = 4;
  localparam int MM [NI] = '{2, 0, 1, 4};
  localparam int NN [NI] = '{8, 0, 4, 4};
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic [3:0]  rst_v;
  logic [3:0]  refr_v;
  logic [3:0]  refre_v;
  logic [15:0] wc  [NI];
  logic        wf  [NI];
  logic [31:0] tot [NI];
  logic [15:0] mr  [NI];
  logic        er  [NI];
  logic        ea  [NI];

  int tests = 0;
  int fails = 0;

  // Sequence model: every sample taken since the last reset, plus sticky flags.
  bit sr [NI][DEPTH];
  bit se [NI][DEPTH];
  int len [NI];
  bit xr [NI];
  bit xa [NI];
  bit prev_er [NI];
  bit prev_ea [NI];

  always #5 clk = ~clk;

  testbench_refr_chk #(.REFRESH_M_IN_N_M(2), .REFRESH_M_IN_N_N(8), .MAX_N(256)) u_m2n8 (
    .clk(clk), .rst(rst_v[0]), .refr(refr_v[0]), .refr_e(refre_v[0]),
    .win_cnt(wc[0]), .win_full(wf[0]), .refr_tot(tot[0]), .max_run(mr[0]),
    .err_rate(er[0]), .err_align(ea[0]));

  testbench_refr_chk #(.REFRESH_M_IN_N_M(0), .REFRESH_M_IN_N_N(0), .MAX_N(256)) u_m0n0 (
    .clk(clk), .rst(rst_v[1]), .refr(refr_v[1]), .refr_e(refre_v[1]),
    .win_cnt(wc[1]), .win_full(wf[1]), .refr_tot(tot[1]), .max_run(mr[1]),
    .err_rate(er[1]), .err_align(ea[1]));

  testbench_refr_chk #(.REFRESH_M_IN_N_M(1), .REFRESH_M_IN_N_N(4), .MAX_N(256)) u_m1n4 (
    .clk(clk), .rst(rst_v[2]), .refr(refr_v[2]), .refr_e(refre_v[2]),
    .win_cnt(wc[2]), .win_full(wf[2]), .refr_tot(tot[2]), .max_run(mr[2]),
    .err_rate(er[2]), .err_align(ea[2]));

  testbench_refr_chk #(.REFRESH_M_IN_N_M(4), .REFRESH_M_IN_N_N(4), .MAX_N(256)) u_m4n4 (
    .clk(clk), .rst(rst_v[3]), .refr(refr_v[3]), .refr_e(refre_v[3]),
    .win_cnt(wc[3]), .win_full(wf[3]), .refr_tot(tot[3]), .max_run(mr[3]),
    .err_rate(er[3]), .err_align(ea[3]));

  function automatic int wsum(int i);
    int n = (len[i] < NN[i]) ? len[i] : NN[i];
    int s = 0;
    for (int k = 0; k < n; k++) s += int'(sr[i][len[i] - 1 - k]);
    return s;
  endfunction

  function automatic int total(int i);
    int s = 0;
    for (int k = 0; k < len[i]; k++) s += int'(sr[i][k]);
    return s;
  endfunction

  function automatic int longest(int i);
    int best = 0;
    int cur  = 0;
    for (int k = 0; k < len[i]; k++) begin
      cur  = sr[i][k] ? cur + 1 : 0;
      best = (cur > best) ? cur : best;
    end
    return best;
  endfunction

  task automatic push(int i, bit rv, bit ev);
    int l = len[i];
    if (l >= DEPTH) $fatal(1, "FAIL model_depth u%0d history overflow", i);
    sr[i][l] = rv;
    se[i][l] = ev;
    len[i]   = l + 1;
    if (NN[i] == 0) begin
      if (rv) xr[i] = 1'b1;
    end else if (len[i] > NN[i] && wsum(i) != MM[i]) begin
      xr[i] = 1'b1;
    end
    if (l >= 1 && rv != se[i][l - 1]) xa[i] = 1'b1;
  endtask

  task automatic chk(string tag, int i, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s u%0d got %0d expected %0d", tag, i, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      chk("win_cnt",   i, 32'(wc[i]),  32'(wsum(i)));
      chk("win_full",  i, 32'(wf[i]),  32'((NN[i] != 0) && (len[i] >= NN[i])));
      chk("refr_tot",  i, tot[i],      32'(total(i)));
      chk("max_run",   i, 32'(mr[i]),  32'(longest(i)));
      chk("err_rate",  i, 32'(er[i]),  32'(xr[i]));
      chk("err_align", i, 32'(ea[i]),  32'(xa[i]));
    end
  endtask

  // One clock: record what the DUTs sample at this edge, then compare after it.
  task automatic tick();
    logic [3:0] r = rst_v;
    logic [3:0] v = refr_v;
    logic [3:0] e = refre_v;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (r[i]) begin
        len[i] = 0;
        xr[i]  = 1'b0;
        xa[i]  = 1'b0;
      end else begin
        push(i, v[i], e[i]);
      end
      if (er[i] === 1'b1 && !prev_er[i])
        $display("[TB] %0t u%0d err_rate set, win_cnt=%0d M=%0d", $time, i, wc[i], MM[i]);
      if (ea[i] === 1'b1 && !prev_ea[i])
        $display("[TB] %0t u%0d err_align set, win_cnt=%0d M=%0d", $time, i, wc[i], MM[i]);
      prev_er[i] = (er[i] === 1'b1);
      prev_ea[i] = (ea[i] === 1'b1);
    end
    check_all();
  endtask

  function automatic bit pat8(int k, int a, int b);
    return ((k % 8) == a) || ((k % 8) == b);
  endfunction

  initial begin
    int a;
    int b;
    for (int i = 0; i < NI; i++) begin
      len[i] = 0; xr[i] = 0; xa[i] = 0; prev_er[i] = 0; prev_ea[i] = 0;
    end

    // Reset with random inputs, which must be ignored.
    rst_v = '1;
    for (int c = 0; c < 4; c++) begin
      refr_v  = 4'($urandom);
      refre_v = 4'($urandom);
      tick();
    end
    rst_v = '0;

    // Generator pairing on all four instances in parallel.
    a = int'($urandom_range(7));
    b = (a + 1) % 8;
    for (int c = 0; c < 200; c++) begin
      int k;
      refr_v[0]  = pat8(c, a, b);
      refre_v[0] = pat8(c + 1, a, b);
      refr_v[1]  = (c == 60);
      refre_v[1] = (c == 59);
      rst_v[2]   = (c == 50 || c == 51);
      if (c < 52) begin
        refr_v[2]  = ((c % 4) == 1) || (c == 43);
        refre_v[2] = ((c % 4) == 0) || (c == 42);
      end else begin
        k = c - 52;
        refr_v[2]  = ((k % 4) == 1);
        refre_v[2] = ((k % 4) == 0);
      end
      refr_v[3]  = 1'b1;
      refre_v[3] = 1'b1;
      tick();
      if (c == 49) chk("m1n4_rate_before_rst", 2, 32'(er[2]), 32'd1);
      if (c == 51) chk("m1n4_cleared", 2, 32'(er[2]) + tot[2] + 32'(wc[2]), 32'd0);
      if (c == 55) chk("m1n4_full_at_4", 2, 32'(wf[2]), 32'd1);
      if (c == 58) chk("n0_quiet", 1, 32'(er[1]) + 32'(wf[1]), 32'd0);
      if (c == 60) chk("n0_single_refr", 1, {31'd0, er[1]} + tot[1], 32'd2);
    end
    chk("gen_win_cnt", 0, 32'(wc[0]), 32'd2);
    chk("gen_max_run", 0, 32'(mr[0]), 32'd2);
    chk("gen_clean",   0, 32'(er[0]) + 32'(ea[0]), 32'd0);
    chk("m1n4_clean",  2, 32'(er[2]) + 32'(ea[2]), 32'd0);
    chk("m4n4_cnt",    3, 32'(wc[3]), 32'd4);
    chk("m4n4_run",    3, 32'(mr[3]), 32'd200);
    chk("m4n4_clean",  3, 32'(er[3]), 32'd0);

    // Rate violation: 2-in-8 pattern plus one extra pulse at sample 30.
    rst_v = '1; refr_v = '0; refre_v = '0;
    tick(); tick();
    rst_v[0] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      refr_v[0]  = pat8(c, 0, 4) || (c == 29);
      refre_v[0] = pat8(c + 1, 0, 4) || (c + 1 == 29);
      tick();
      if (c == 28) chk("rate_pre", 0, 32'(er[0]), 32'd0);
      if (c == 29) begin
        chk("rate_cnt3", 0, 32'(wc[0]), 32'd3);
        chk("rate_set",  0, 32'(er[0]), 32'd1);
      end
    end
    chk("rate_sticky", 0, 32'(er[0]), 32'd1);
    chk("rate_no_align", 0, 32'(ea[0]), 32'd0);

    // Alignment violation: refr_e at sample 10 with no refr at sample 11.
    rst_v[0] = 1'b1; refr_v[0] = 1'b0; refre_v[0] = 1'b0;
    tick(); tick();
    rst_v[0] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      refr_v[0]  = 1'b0;
      refre_v[0] = (c == 9);
      tick();
      if (c == 7) chk("align_rate_unaffected", 0, 32'(er[0]), 32'd0);
      if (c == 9) chk("align_pre", 0, 32'(ea[0]), 32'd0);
      if (c == 10) chk("align_set", 0, 32'(ea[0]), 32'd1);
    end

    // Random traffic with occasional resets on every instance.
    rst_v = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NI; i++) begin
        rst_v[i]   = ($urandom_range(29) == 0);
        refr_v[i]  = ($urandom_range(3) == 0);
        refre_v[i] = ($urandom_range(3) == 0);
      end
      if (c < 100) refr_v[3] = ($urandom_range(7) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
